// File: rtl/serializador_paralelo_serie_pkg.sv
// rtl/serializador_paralelo_serie_pkg.sv - shared types and helpers for the parallel-to-serial transmitter
package serializador_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } estado_t;

    // Counter width helper: a 1-value range still needs a 1-bit register.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serializador_paralelo_serie_if.sv
// rtl/serializador_paralelo_serie_if.sv - load handshake and serial line bundle
interface serializador_paralelo_serie_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d;
    logic             ld;
    logic             rdy;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output d, ld,
        input  rdy, sout, busy, done
    );

    modport slave (
        input  d, ld,
        output rdy, sout, busy, done
    );
endinterface

// File: rtl/serializador_paralelo_serie_registrador.sv
// rtl/serializador_paralelo_serie_registrador.sv - parallel-load, shift-right register exposing bit 0
module registrador_deslocamento #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             sh,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (sh) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign q0 = q[0];
endmodule

// File: rtl/serializador_paralelo_serie.sv
// rtl/serializador_paralelo_serie.sv - framed serial transmitter: start, data LSB first, even parity, stop
module serializador_paralelo_serie
    import serializador_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    serializador_paralelo_serie_if.slave   bus
);
    localparam int CW = clog2_min1(BIT_CYCLES);
    localparam int IW = clog2_min1(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    estado_t       state, state_next;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          par;
    logic          done_q;
    logic          done_next;
    logic          accept;
    logic          shift;
    logic          bit_end;
    logic          data_bit;

    assign bit_end = (cnt == CNT_LAST);

    registrador_deslocamento #(.WIDTH(WIDTH)) u_shreg (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .ld  (accept),
        .sh  (shift),
        .d   (bus.d),
        .q0  (data_bit)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            par    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
            // Every state change coincides with bit_end, so this also clears on transitions.
            cnt    <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
            if (accept) begin
                par <= ^bus.d;
            end
            if (state != DATA) begin
                idx <= '0;
            end else if (bit_end) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shift      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ld && !clr) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            START:   bus.sout = 1'b0;
            DATA:    bus.sout = data_bit;
            PARITY:  bus.sout = par;
            default: bus.sout = 1'b1;
        endcase
    end

    assign bus.rdy  = (state == IDLE);
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_serializador_paralelo_serie.sv
// tb/tb_serializador_paralelo_serie.sv - directed self-checking bench, WIDTH=4 BIT_CYCLES=2 PARITY_EN=1
module tb_serializador_paralelo_serie;
    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    serializador_paralelo_serie_if #(.WIDTH(4)) bus ();

    serializador_paralelo_serie #(
        .WIDTH      (4),
        .BIT_CYCLES (2),
        .PARITY_EN  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " sout"}, 8'(bus.sout), 8'd1);
        chk({tag, " rdy"},  8'(bus.rdy),  8'd1);
        chk({tag, " busy"}, 8'(bus.busy), 8'd0);
    endtask

    // bits[k] is the expected line level of serial bit k (0=start ... 6=stop).
    task automatic frame(input string tag, input logic [6:0] bits, input int ld_at, input logic [3:0] dv);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d sout", tag, i), 8'(bus.sout), 8'(bits[(i-1)/2]));
            chk($sformatf("%s c%0d busy", tag, i), 8'(bus.busy), 8'd1);
            chk($sformatf("%s c%0d rdy", tag, i),  8'(bus.rdy),  8'd0);
            chk($sformatf("%s c%0d done", tag, i), 8'(bus.done), 8'd0);
            if (i == ld_at) begin
                bus.ld = 1'b1;
                bus.d  = dv;
            end else if (ld_at != 0 && i == ld_at + 1) begin
                bus.ld = 1'b0;
            end
        end
    endtask

    task automatic end_chk(input string tag);
        @(negedge clk);
        chk({tag, " done"}, 8'(bus.done), 8'd1);
        idle_chk(tag);
    endtask

    initial begin
        rst    = 1'b1;
        clr    = 1'b0;
        bus.ld = 1'b1;
        bus.d  = 4'hF;

        @(negedge clk);
        idle_chk("rst");
        chk("rst done", 8'(bus.done), 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.ld = 1'b0;
        @(negedge clk);
        idle_chk("post rst");
        chk("post rst done", 8'(bus.done), 8'd0);

        // Single frame of 1011.
        @(negedge clk);
        bus.d  = 4'b1011;
        bus.ld = 1'b1;
        @(posedge clk);
        #1 bus.ld = 1'b0;
        frame("single", 7'b1110110, 0, 4'h0);
        end_chk("single end");
        @(negedge clk);
        idle_chk("single after");
        chk("single after done", 8'(bus.done), 8'd0);

        // Back-to-back with ld held high; d changes right after the first accept.
        bus.d  = 4'h0;
        bus.ld = 1'b1;
        @(posedge clk);
        #1 bus.d = 4'hF;
        frame("b2b0", 7'b1000000, 0, 4'h0);
        end_chk("b2b gap");
        @(posedge clk);
        #1 bus.ld = 1'b0;
        frame("b2b1", 7'b1011110, 0, 4'h0);
        end_chk("b2b end");
        @(negedge clk);
        idle_chk("b2b after");

        // ld with new data in cycle 5 must not disturb the frame.
        bus.d  = 4'h6;
        bus.ld = 1'b1;
        @(posedge clk);
        #1 bus.ld = 1'b0;
        frame("busyld", 7'b1001100, 5, 4'hA);
        end_chk("busyld end");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_chk("busyld no second");
        end

        // clr during data bit 2 of 0101.
        bus.d  = 4'h5;
        bus.ld = 1'b1;
        @(posedge clk);
        #1 bus.ld = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("clr c%0d sout", i), 8'(bus.sout), 8'(7'b1001010 >> ((i-1)/2)) & 8'd1);
        end
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        idle_chk("clr next");
        chk("clr next done", 8'(bus.done), 8'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("clr no done", 8'(bus.done), 8'd0);
            chk("clr stays idle", 8'(bus.busy), 8'd0);
        end
        bus.d  = 4'h9;
        bus.ld = 1'b1;
        @(posedge clk);
        #1 bus.ld = 1'b0;
        frame("after clr", 7'b1010010, 0, 4'h0);
        end_chk("after clr end");

        // clr and ld together in IDLE.
        @(negedge clk);
        clr    = 1'b1;
        bus.ld = 1'b1;
        bus.d  = 4'h3;
        @(posedge clk);
        #1 clr = 1'b0;
        bus.ld = 1'b0;
        @(negedge clk);
        idle_chk("clr+ld");
        @(negedge clk);
        idle_chk("clr+ld later");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serializador_paralelo_serie.md
# serializador_paralelo_serie

Parallel-in/serial-out transmitter. It is the unload side of the team's 4-bit parallel-load register. It accepts a parallel word through a load/ready handshake and shifts it out on a single line as a framed bit stream: start bit, data LSB first, optional even parity, stop bit. Each bit is held for a programmable number of clock cycles. It sits between a parallel-load register and any serial consumer (pin, link, or matching receiver).

## Interface
- WIDTH, 4, data word width (≥2)
- BIT_CYCLES, 4, clock cycles per serial bit (≥1)
- PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- clr  input  1  synchronous abort; lower priority than rst
- d  input  WIDTH  parallel word; sampled only on accept
- ld  input  1  load request (valid)
- rdy  output  1  ready to accept; high only in IDLE
- sout  output  1  serial line; idle level 1
- busy  output  1  frame in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse on normal frame completion

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: at a rising edge where ld && rdy && !clr && !rst.
  - Load d into the shift register.
  - Capture parity = ^d.
  - Go to START.
- START: sout=0.
- DATA: sout = shift_reg[0]. Shift right at the end of each bit period. The bit index runs 0..WIDTH-1.
- After the last data bit:
  - Go to PARITY if PARITY_EN, else to STOP.
- PARITY: sout = captured parity, which gives an even total count of ones over data+parity.
- STOP: sout=1. At the end of the period, go to IDLE and assert done for that one IDLE cycle.
- Bit-period counter:
  - Counts 0..BIT_CYCLES-1 in every non-IDLE state.
  - A state or bit advances when count == BIT_CYCLES-1.
  - The counter clears on every state change.
- ld while busy: ignored, with no effect on the current frame. d changes after accept are ignored.
- rst: state=IDLE, sout=1, rdy=1, busy=0, done=0, counters and shift register cleared.
- clr (rst low):
  - Same register effect as rst on the next edge. done is not pulsed.
  - clr && ld in IDLE: clr wins and no frame is accepted.
- All outputs are registered or decoded from registered state only. There is no combinational path from d, ld or clr to any output.

## Timing
- Reset values: sout=1, rdy=1, busy=0, done=0.
- Frame length: F = (2 + WIDTH + PARITY_EN) × BIT_CYCLES cycles.
- Latency:
  - Accept at edge E0.
  - sout=0 from the cycle after E0.
  - The frame occupies cycles 1..F.
  - done=1 and rdy=1 in cycle F+1.
- Back-to-back: ld held high is accepted at the edge ending cycle F+1. Consecutive frames are separated by exactly one idle cycle with sout=1.
- BIT_CYCLES=1: each bit lasts one cycle and the counter is degenerate (width clamped to 1).
- rst or clr mid-frame: takes effect at the next edge. sout=1 from the following cycle and the partial frame is discarded.

## Structure
- Package serializador_pkg:
  - estado_t enum (IDLE, START, DATA, PARITY, STOP).
  - Function for counter widths: $clog2 with minimum 1.
- Sub-module registrador_deslocamento:
  - WIDTH-bit register with synchronous rst/clr, ld (parallel load), sh (shift right, 0 in).
  - Output q[0].
- The top level holds the FSM, bit-period counter, bit index counter and parity flop.

## Test plan
All scenarios use WIDTH=4, BIT_CYCLES=2, PARITY_EN=1, so F=14.
- Reset: rst=1 for 2 cycles, with ld=1 and d=4'hF -> sout=1, rdy=1, busy=0, done=0, and no frame starts.
- Single frame: d=4'b1011, ld pulsed 1 cycle.
  - sout pairs are 0,1,1,0,1,1,1 (start, data LSB first, parity=1, stop).
  - Cycles 1–14; done=1 only in cycle 15.
- Back-to-back: ld held high, d=4'h0 then 4'hF at the second accept.
  - Frames 0,0,0,0,0,0,1 and 0,1,1,1,1,0,1.
  - Exactly one idle cycle with sout=1 between them.
- Load during busy: accept 4'h6, then assert ld with d=4'hA in cycle 5.
  - The frame carries 0,1,1,0 data with parity 0.
  - No second frame follows.
- clr mid-frame: accept 4'h5, assert clr during the data bit 2 period.
  - Next cycle: sout=1, rdy=1, busy=0, and done is never asserted.
  - A following accept of 4'h9 yields a full correct frame with parity 0.
- clr && ld in IDLE with d=4'h3 -> rdy stays 1, busy stays 0, sout stays 1.
